// File: rtl/sram_pkg.sv
// Shared widths, FSM state encoding and read-tag format for the SRAM arbiter.
package sram_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CONF_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/sram_rsp_tracker.sv
// Follows each issued read through the fixed SRAM latency and says who owns
// the data leaving the macro; also counts reads still in flight.
module sram_rsp_tracker
    import sram_pkg::*;
#(
    parameter int READ_LATENCY = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_id,
    output logic pop,
    output logic pop_id,
    output logic busy
);

    tag_t       tags [READ_LATENCY+1];
    logic [3:0] count;

    // Stage 0 is loaded on the grant edge, so the last stage lines up with
    // the cycle in which sram_dout carries that read's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= READ_LATENCY; i++) begin
                tags[i] <= '0;
            end
            count <= 4'd0;
        end else begin
            tags[0].valid <= push;
            tags[0].id    <= push_id;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    assign pop    = tags[READ_LATENCY].valid;
    assign pop_id = tags[READ_LATENCY].id;
    assign busy   = (count != 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sharing of the single SRAM port between two requesters, with
// registered command pins, in-order read return and drain-before-conf-switch.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int READ_LATENCY = 3
) (
    input  logic              sram_clk,
    input  logic              sram_rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [CONF_W-1:0] req0_conf,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [CONF_W-1:0] req1_conf,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic [CONF_W-1:0] sram_conf,
    input  logic [DATA_W-1:0] sram_dout
);

    state_t            state, next_state;
    logic              rr_ptr;
    logic              busy, pop, pop_id;
    logic              prio_valid, cand_valid, cand_id, cand_ok, grant;
    logic              win_we;
    logic [CONF_W-1:0] cand_conf;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // The candidate is the first valid requester in priority order; if it
    // cannot run because of a conf change, nobody is granted around it.
    always_comb begin
        prio_valid = rr_ptr ? req1_valid : req0_valid;
        cand_id    = prio_valid ? rr_ptr : !rr_ptr;
        cand_valid = req0_valid || req1_valid;
        cand_conf  = cand_id ? req1_conf  : req0_conf;
        win_we     = cand_id ? req1_we    : req0_we;
        win_addr   = cand_id ? req1_addr  : req0_addr;
        win_wdata  = cand_id ? req1_wdata : req0_wdata;
        cand_ok    = (cand_conf == sram_conf) || !busy;
        grant      = 1'b0;
        next_state = state;
        case (state)
            IDLE, ISSUE: begin
                if (!cand_valid) begin
                    next_state = IDLE;
                end else if (cand_ok) begin
                    grant      = 1'b1;
                    next_state = ISSUE;
                end else begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!busy) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        req0_ready = grant && !cand_id;
        req1_ready = grant && cand_id;
    end

    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state <= next_state;
            if (grant) rr_ptr <= !cand_id;
        end
    end

    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            sram_csb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_addr <= '0;
            sram_din  <= '0;
            sram_conf <= '0;
        end else if (grant) begin
            sram_csb  <= 1'b0;
            sram_web  <= !win_we;
            sram_addr <= win_addr;
            sram_din  <= win_wdata;
            sram_conf <= cand_conf;
        end else begin
            sram_csb <= 1'b1;
            sram_web <= 1'b1;
        end
    end

    sram_rsp_tracker #(
        .READ_LATENCY(READ_LATENCY)
    ) u_tracker (
        .clk    (sram_clk),
        .rst_n  (sram_rst_n),
        .push   (grant && !win_we),
        .push_id(cand_id),
        .pop    (pop),
        .pop_id (pop_id),
        .busy   (busy)
    );

    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= pop && !pop_id;
            rsp1_valid <= pop && pop_id;
            if (pop && !pop_id) rsp0_rdata <= sram_dout;
            if (pop && pop_id)  rsp1_rdata <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM (two sync stages
// plus one macro cycle) and a log of returned responses.
module tb_sram_arbiter;

    logic        sram_clk = 1'b0;
    logic        sram_rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [11:0] req0_addr = '0;
    logic [31:0] req0_wdata = '0;
    logic [1:0]  req0_conf = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [11:0] req1_addr = '0;
    logic [31:0] req1_wdata = '0;
    logic [1:0]  req1_conf = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        sram_csb, sram_web;
    logic [11:0] sram_addr;
    logic [31:0] sram_din;
    logic [1:0]  sram_conf;
    logic [31:0] sram_dout = '0;

    int checks = 0;
    int failures = 0;
    int both_high = 0;
    int          rsp_id_q[$];
    logic [31:0] rsp_data_q[$];

    sram_arbiter dut (
        .sram_clk  (sram_clk),
        .sram_rst_n(sram_rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_we   (req0_we),
        .req0_addr (req0_addr),
        .req0_wdata(req0_wdata),
        .req0_conf (req0_conf),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_we   (req1_we),
        .req1_addr (req1_addr),
        .req1_wdata(req1_wdata),
        .req1_conf (req1_conf),
        .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_conf (sram_conf),
        .sram_dout (sram_dout)
    );

    always #5 sram_clk = ~sram_clk;

    // Unwritten locations read back as C0DE0<addr>, except 0x010.
    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
    endfunction

    logic        s0_csb = 1'b1, s0_web = 1'b1, s1_csb = 1'b1, s1_web = 1'b1;
    logic [11:0] s0_addr = '0, s1_addr = '0;
    logic [31:0] s0_din = '0, s1_din = '0;
    logic [31:0] mem [int];

    always @(posedge sram_clk) begin
        s0_csb  <= sram_csb;
        s0_web  <= sram_web;
        s0_addr <= sram_addr;
        s0_din  <= sram_din;
        s1_csb  <= s0_csb;
        s1_web  <= s0_web;
        s1_addr <= s0_addr;
        s1_din  <= s0_din;
        if (!s1_csb) begin
            if (!s1_web) mem[int'(s1_addr)] = s1_din;
            else sram_dout <= mem.exists(int'(s1_addr)) ? mem[int'(s1_addr)] : init_val(s1_addr);
        end
    end

    always @(negedge sram_clk) begin
        if (sram_rst_n) begin
            if (rsp0_valid && rsp1_valid) both_high++;
            if (rsp0_valid) begin
                rsp_id_q.push_back(0);
                rsp_data_q.push_back(rsp0_rdata);
            end
            if (rsp1_valid) begin
                rsp_id_q.push_back(1);
                rsp_data_q.push_back(rsp1_rdata);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n, input logic v, input logic we, input logic [11:0] a,
                                 input logic [31:0] d, input logic [1:0] c);
        if (n == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_conf = c;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_conf = c;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sram_clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_csb"},   sram_csb, 1'b1);
        checkOutput({tag, "_web"},   sram_web, 1'b1);
        checkOutput({tag, "_addr"},  sram_addr, 12'h000);
        checkOutput({tag, "_din"},   sram_din, 32'h0);
        checkOutput({tag, "_conf"},  sram_conf, 2'd0);
        checkOutput({tag, "_v0"},    rsp0_valid, 1'b0);
        checkOutput({tag, "_v1"},    rsp1_valid, 1'b0);
        checkOutput({tag, "_d0"},    rsp0_rdata, 32'h0);
        checkOutput({tag, "_d1"},    rsp1_rdata, 32'h0);
        checkOutput({tag, "_rdy0"},  req0_ready, 1'b0);
        checkOutput({tag, "_rdy1"},  req1_ready, 1'b0);
    endtask

    task automatic checkResponses(input string tag, input int n, input int ids[6], input logic [31:0] data[6]);
        checkOutput({tag, "_count"}, rsp_id_q.size(), n);
        for (int j = 0; j < n; j++) begin
            checkOutput($sformatf("%s_id%0d", tag, j),
                        (j < rsp_id_q.size()) ? rsp_id_q[j] : -1, ids[j]);
            checkOutput($sformatf("%s_data%0d", tag, j),
                        (j < rsp_data_q.size()) ? rsp_data_q[j] : 32'hxxxxxxxx, data[j]);
        end
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          grant_seq[6];
        int          ids[6];
        logic [31:0] data[6];

        $display("[TB] reset and idle");
        tick(2);
        checkResetState("rst_hold");
        sram_rst_n = 1'b1;
        tick(1);
        checkResetState("rst_rel");
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput($sformatf("idle_csb%0d", k), sram_csb, 1'b1);
        end

        $display("[TB] single read from requester 0");
        rsp_id_q.delete(); rsp_data_q.delete();
        applyStimulus(0, 1, 0, 12'h010, 32'h0, 2'd0);
        #1;
        checkOutput("rd0_ready0", req0_ready, 1'b1);
        checkOutput("rd0_ready1", req1_ready, 1'b0);
        tick(1);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 2'd0);
        checkOutput("rd0_csb", sram_csb, 1'b0);
        checkOutput("rd0_web", sram_web, 1'b1);
        checkOutput("rd0_addr", sram_addr, 12'h010);
        for (int k = 2; k <= 4; k++) begin
            tick(1);
            checkOutput($sformatf("rd0_early_v0_t%0d", k), rsp0_valid, 1'b0);
        end
        tick(1);
        checkOutput("rd0_v0_t5", rsp0_valid, 1'b1);
        checkOutput("rd0_data_t5", rsp0_rdata, 32'hDEADBEEF);
        checkOutput("rd0_v1_t5", rsp1_valid, 1'b0);
        tick(1);
        checkOutput("rd0_v0_t6", rsp0_valid, 1'b0);
        tick(2);
        ids  = '{0, 0, 0, 0, 0, 0};
        data = '{32'hDEADBEEF, 0, 0, 0, 0, 0};
        checkResponses("rd0_log", 1, ids, data);

        $display("[TB] single read from requester 1");
        rsp_id_q.delete(); rsp_data_q.delete();
        applyStimulus(1, 1, 0, 12'h020, 32'h0, 2'd0);
        #1;
        checkOutput("rd1_ready1", req1_ready, 1'b1);
        tick(1);
        applyStimulus(1, 0, 0, 12'h000, 32'h0, 2'd0);
        checkOutput("rd1_addr", sram_addr, 12'h020);
        tick(6);
        ids  = '{1, 0, 0, 0, 0, 0};
        data = '{32'hC0DE0020, 0, 0, 0, 0, 0};
        checkResponses("rd1_log", 1, ids, data);

        $display("[TB] both requesters contend");
        rsp_id_q.delete(); rsp_data_q.delete();
        grant_seq = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, 12'h040 + 12'((i + 1) / 2), 32'h0, 2'd0);
            applyStimulus(1, 1, 0, 12'h050 + 12'(i / 2), 32'h0, 2'd0);
            #1;
            checkOutput($sformatf("rr_ready0_c%0d", i), req0_ready, grant_seq[i] == 0);
            checkOutput($sformatf("rr_ready1_c%0d", i), req1_ready, grant_seq[i] == 1);
            tick(1);
        end
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 2'd0);
        applyStimulus(1, 0, 0, 12'h000, 32'h0, 2'd0);
        tick(8);
        ids  = '{0, 1, 0, 1, 0, 1};
        data = '{32'hC0DE0040, 32'hC0DE0050, 32'hC0DE0041, 32'hC0DE0051, 32'hC0DE0042, 32'hC0DE0052};
        checkResponses("rr_log", 6, ids, data);

        $display("[TB] write then read back");
        rsp_id_q.delete(); rsp_data_q.delete();
        applyStimulus(0, 1, 1, 12'h0FF, 32'h12345678, 2'd0);
        #1;
        checkOutput("wr_ready0", req0_ready, 1'b1);
        tick(1);
        applyStimulus(0, 1, 0, 12'h0FF, 32'h0, 2'd0);
        checkOutput("wr_csb", sram_csb, 1'b0);
        checkOutput("wr_web", sram_web, 1'b0);
        checkOutput("wr_addr", sram_addr, 12'h0FF);
        checkOutput("wr_din", sram_din, 32'h12345678);
        #1;
        checkOutput("wr_rd_ready0", req0_ready, 1'b1);
        tick(1);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 2'd0);
        checkOutput("wr_rd_csb", sram_csb, 1'b0);
        checkOutput("wr_rd_web", sram_web, 1'b1);
        checkOutput("wr_rd_addr", sram_addr, 12'h0FF);
        tick(6);
        ids  = '{0, 0, 0, 0, 0, 0};
        data = '{32'h12345678, 0, 0, 0, 0, 0};
        checkResponses("wr_log", 1, ids, data);

        $display("[TB] conf switch drains outstanding reads");
        rsp_id_q.delete(); rsp_data_q.delete();
        applyStimulus(0, 1, 0, 12'h060, 32'h0, 2'd0);
        #1;
        checkOutput("cf_ready0_k0", req0_ready, 1'b1);
        tick(1);
        applyStimulus(0, 1, 0, 12'h062, 32'h0, 2'd0);
        applyStimulus(1, 1, 0, 12'h061, 32'h0, 2'd2);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick(1);
            #1;
            checkOutput($sformatf("cf_ready0_k%0d", k), req0_ready, 1'b0);
            checkOutput($sformatf("cf_ready1_k%0d", k), req1_ready, 1'b0);
        end
        tick(1);
        #1;
        checkOutput("cf_ready1_k6", req1_ready, 1'b1);
        checkOutput("cf_ready0_k6", req0_ready, 1'b0);
        tick(1);
        applyStimulus(1, 0, 0, 12'h000, 32'h0, 2'd0);
        checkOutput("cf_conf_k7", sram_conf, 2'd2);
        checkOutput("cf_csb_k7", sram_csb, 1'b0);
        for (int k = 7; k <= 11; k++) begin
            if (k > 7) tick(1);
            #1;
            checkOutput($sformatf("cf_back_ready0_k%0d", k), req0_ready, 1'b0);
        end
        tick(1);
        #1;
        checkOutput("cf_back_ready0_k12", req0_ready, 1'b1);
        tick(1);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 2'd0);
        checkOutput("cf_conf_k13", sram_conf, 2'd0);
        checkOutput("cf_addr_k13", sram_addr, 12'h062);
        tick(6);
        ids  = '{0, 1, 0, 0, 0, 0};
        data = '{32'hC0DE0060, 32'hC0DE0061, 32'hC0DE0062, 0, 0, 0};
        checkResponses("cf_log", 3, ids, data);

        $display("[TB] reset during an in-flight read");
        rsp_id_q.delete(); rsp_data_q.delete();
        applyStimulus(0, 1, 0, 12'h070, 32'h0, 2'd0);
        #1;
        checkOutput("mr_ready0", req0_ready, 1'b1);
        tick(1);
        applyStimulus(0, 0, 0, 12'h000, 32'h0, 2'd0);
        checkOutput("mr_csb", sram_csb, 1'b0);
        tick(1);
        sram_rst_n = 1'b0;
        #1;
        checkResetState("mr_rst");
        tick(1);
        sram_rst_n = 1'b1;
        tick(8);
        checkOutput("mr_no_rsp", rsp_id_q.size(), 0);
        checkOutput("mr_csb_after", sram_csb, 1'b1);

        checkOutput("rsp_both_high", both_high, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
